// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: request/result bundle between the value source, the converter and the digit decoders.
// Latency: none; plain wires.
// Backpressure: none; start is a request that the converter may ignore while busy or during done.
interface bin_to_bcd_seq_if #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [IN_W-1:0]       bin_in;
  logic                  enable;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd_out;

  // Value source / display controller side.
  modport master (
    output start, bin_in, enable,
    input  busy, done, overflow, bcd_out
  );

  // Converter side.
  modport slave (
    input  start, bin_in, enable,
    output busy, done, overflow, bcd_out
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary-to-BCD converter, one input bit per clock, saturating to all-9s.
// Latency: start accepted at edge 0 -> busy for IN_W cycles, done pulse after edge IN_W+1.
// Backpressure: none; start is ignored while busy or during the done cycle. Optional macro: LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int         IN_W       = 16,
  parameter int         DIGITS     = 5,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input logic             clk,
  input logic             rst_n,
  bin_to_bcd_seq_if.slave bus
);
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int SCR_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              load;
  logic              step;
  logic              finish;

  logic [IN_W-1:0]   shift_q;
  logic [SCR_W-1:0]  scratch_q;
  logic [SCR_W-1:0]  scratch_adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_sticky_q;

  logic [SCR_W-1:0]  result_q;
  logic              overflow_q;
  logic              done_q;
  logic [SCR_W-1:0]  bcd_mask;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath controls; done_q blocks a start landing in the done cycle.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !done_q) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Add-3 correction of every scratch digit that would reach 10 or more after doubling.
  always_comb begin
    scratch_adj = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        scratch_adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Shift engine: capture on accept, then shift one bit per cycle; a 1 leaving the top digit means >= 10^DIGITS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      scratch_q    <= '0;
      cnt_q        <= '0;
      ovf_sticky_q <= 1'b0;
    end else if (load) begin
      shift_q      <= bus.bin_in;
      scratch_q    <= '0;
      cnt_q        <= CNT_W'(IN_W);
      ovf_sticky_q <= 1'b0;
    end else if (step) begin
      scratch_q <= {scratch_adj[SCR_W-2:0], shift_q[IN_W-1]};
      shift_q   <= {shift_q[IN_W-2:0], 1'b0};
      cnt_q     <= cnt_q - CNT_W'(1);
      if (scratch_adj[SCR_W-1]) begin
        ovf_sticky_q <= 1'b1;
      end
    end
  end

  // Result register: updated only on the FINISH edge, saturating to all nines on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        result_q   <= ovf_sticky_q ? {DIGITS{4'h9}} : scratch_q;
        overflow_q <= ovf_sticky_q;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
`endif

  // Display masking: purely combinational so enable never touches the stored result.
  always_comb begin
    bcd_mask = result_q;
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    if (!overflow_q) begin
      for (int k = DIGITS - 1; k >= 1; k--) begin
        if (lead && (result_q[4*k +: 4] == 4'd0)) begin
          bcd_mask[4*k +: 4] = BLANK_CODE;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
    if (!bus.enable) begin
      bcd_mask = {DIGITS{BLANK_CODE}};
    end
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.bcd_out  = bcd_mask;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: drives a 5-digit and a 4-digit converter with the same stimulus.
// An arithmetic reference (divide/modulo) predicts every output each cycle; literal values pin the reference.
// Honours LEADING_ZERO_BLANK_EN when the build defines it.
module tb_bin_to_bcd_seq;
  localparam int IN_W = 16;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        start  = 1'b0;
  logic [15:0] bin_in = '0;
  logic        enable = 1'b1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.IN_W(IN_W), .DIGITS(5)) if5 ();
  bin_to_bcd_seq_if #(.IN_W(IN_W), .DIGITS(4)) if4 ();

  assign if5.start  = start;
  assign if5.bin_in = bin_in;
  assign if5.enable = enable;
  assign if4.start  = start;
  assign if4.bin_in = bin_in;
  assign if4.enable = enable;

  bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(5), .BLANK_CODE(4'hF)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(if5)
  );
  bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(4), .BLANK_CODE(4'hF)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion by repeated divide/modulo; saturates to all nines at or above 10^d.
  function automatic logic [31:0] ref_conv(input int unsigned v, input int d, output bit ovf);
    logic [31:0] r   = '0;
    int unsigned x   = v;
    int unsigned lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    ovf = (v >= lim);
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = ovf ? 4'd9 : 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // What the display should show for a stored result.
  function automatic logic [31:0] shown(input logic [31:0] r, input bit ovf, input bit en, input int d);
    logic [31:0] s    = r;
    bit          lead = 1'b1;
    if (!en) begin
      s = '0;
      for (int i = 0; i < d; i++) s[4*i +: 4] = 4'hF;
      return s;
    end
    if (LZB && !ovf) begin
      for (int i = d - 1; i >= 1; i--) begin
        if (lead && r[4*i +: 4] == 4'd0) s[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
    return s;
  endfunction

  // Cycle-level reference: m_t counts edges since the accepting edge, -1 when idle.
  int          m_t = -1;
  int unsigned m_val = 0;
  logic [31:0] m_res5 = '0;
  logic [31:0] m_res4 = '0;
  bit          m_ovf5 = 1'b0;
  bit          m_ovf4 = 1'b0;
  bit          m_done = 1'b0;
  bit          was_done = 1'b0;
  bit          cmp_on = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = -1; m_res5 = '0; m_res4 = '0; m_ovf5 = 1'b0; m_ovf4 = 1'b0; m_done = 1'b0;
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      if (m_t >= 0) begin
        m_t++;
        if (m_t == IN_W + 1) begin
          m_res5 = ref_conv(m_val, 5, m_ovf5);
          m_res4 = ref_conv(m_val, 4, m_ovf4);
          m_done = 1'b1;
          m_t    = -1;
        end
      end else if (start && !was_done) begin
        m_t   = 0;
        m_val = int'(bin_in);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("busy5", if5.busy, (m_t >= 0 && m_t < IN_W));
      chk("done5", if5.done, m_done);
      chk("ovf5",  if5.overflow, m_ovf5);
      chk("bcd5",  if5.bcd_out, shown(m_res5, m_ovf5, enable, 5));
      chk("busy4", if4.busy, (m_t >= 0 && m_t < IN_W));
      chk("done4", if4.done, m_done);
      chk("ovf4",  if4.overflow, m_ovf4);
      chk("bcd4",  if4.bcd_out, shown(m_res4, m_ovf4, enable, 4));
    end
  end

  // Waits (bounded) for done; call from #1 after a clock edge.
  task automatic wait_done(output int done_at, output int busy_cycles);
    bit seen = 1'b0;
    done_at = -1;
    busy_cycles = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (if5.busy) busy_cycles++;
      if (if5.done) begin
        seen = 1'b1;
        done_at = n;
      end
    end
    chk("done_seen", seen, 1'b1);
  endtask

  // Idles one cycle, requests a conversion of v, returns in the done cycle.
  task automatic convert(input int unsigned v, output int done_at, output int busy_cycles);
    int bc;
    @(posedge clk); #1;
    start  = 1'b1;
    bin_in = v[15:0];
    @(posedge clk); #1;
    start = 1'b0;
    bc = if5.busy ? 1 : 0;
    wait_done(done_at, busy_cycles);
    busy_cycles = busy_cycles + bc;
  endtask

  initial begin
    int da;
    int bc;
    int ndone;
    #1 rst_n = 1'b0;
    #1 cmp_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bcd5", if5.bcd_out, LZB ? 32'h000FFFF0 : 32'h0);
    chk("rst_busy5", if5.busy, 1'b0);
    rst_n = 1'b1;

    // Full-scale value: latency and busy length.
    convert(65535, da, bc);
    chk("lat_done_edge", da, 17);
    chk("busy_cycles", bc, 16);
    chk("ffff_bcd5", if5.bcd_out, 32'h00065535);
    chk("ffff_ovf5", if5.overflow, 1'b0);
    chk("ffff_ovf4", if4.overflow, 1'b1);
    chk("ffff_bcd4", if4.bcd_out, 32'h00009999);

    convert(12345, da, bc);
    chk("12345_bcd5", if5.bcd_out, 32'h00012345);

    convert(0, da, bc);
    chk("zero_bcd5", if5.bcd_out, LZB ? 32'h000FFFF0 : 32'h0);

    // 4-digit overflow boundary.
    convert(10000, da, bc);
    chk("10000_ovf4", if4.overflow, 1'b1);
    chk("10000_bcd4", if4.bcd_out, 32'h00009999);
    chk("10000_bcd5", if5.bcd_out, LZB ? 32'h00010000 : 32'h00010000);
    convert(9999, da, bc);
    chk("9999_ovf4", if4.overflow, 1'b0);
    chk("9999_bcd4", if4.bcd_out, 32'h00009999);

    // Extra start pulses during a conversion are ignored.
    @(posedge clk); #1;
    start = 1'b1; bin_in = 16'd500;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (if5.done) ndone++;
      if (n == 3 || n == 10) start = 1'b1;
    end
    chk("500_one_done", ndone, 1);
    chk("500_bcd5", if5.bcd_out, LZB ? 32'h000FF500 : 32'h00000500);

    // Start in the done cycle is ignored; held into the next cycle it is accepted.
    convert(321, da, bc);
    chk("321_bcd5", if5.bcd_out, LZB ? 32'h000FF321 : 32'h00000321);
    start = 1'b1; bin_in = 16'd654;
    @(posedge clk); #1;
    chk("start_in_done_ignored", if5.busy, 1'b0);
    @(posedge clk); #1;
    chk("start_after_done_accepted", if5.busy, 1'b1);
    start = 1'b0;
    bin_in = 16'd1111;
    wait_done(da, bc);
    chk("654_bcd5", if5.bcd_out, LZB ? 32'h000FF654 : 32'h00000654);

    // Reset in the middle of a conversion.
    @(posedge clk); #1;
    start = 1'b1; bin_in = 16'd40000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", if5.busy, 1'b0);
    chk("midrst_bcd5", if5.bcd_out, LZB ? 32'h000FFFF0 : 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 24; n++) begin
      @(posedge clk); #1;
      if (if5.done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    convert(40000, da, bc);
    chk("40000_bcd5", if5.bcd_out, 32'h00040000);

    // Display blanking does not disturb the result.
    enable = 1'b0;
    convert(777, da, bc);
    chk("blank_bcd5", if5.bcd_out, 32'h000FFFFF);
    chk("blank_bcd4", if4.bcd_out, 32'h0000FFFF);
    @(posedge clk); #1;
    enable = 1'b1;
    #1;
    chk("unblank_bcd5", if5.bcd_out, LZB ? 32'h000FF777 : 32'h00000777);
    chk("unblank_bcd4", if4.bcd_out, LZB ? 32'h0000F777 : 32'h00000777);

    @(posedge clk); #1;
    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
